// File: rtl/alu_issue_stage.sv
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Issue/sequencing stage in front of an external 16-bit ALU.
//                Latches one operation, holds the ALU inputs for its execute
//                window, captures result and flags, and presents them on a
//                valid/ready handshake. Optional macro: ALU_DIVZERO_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [3:0]  op_sel,
  input  logic        op_cin,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res,
  output logic        res_carry,
  output logic        res_zero,
  output logic        res_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] c_muldiv_load = 4'(MULDIV_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_sel;
  logic        r_cin;
  logic        w_accept;
  logic        w_capture;
  logic        w_is_muldiv;
  logic        w_carry_op;
  logic        w_div_zero;
  logic [3:0]  w_cnt_load;

  assign w_accept    = in_valid & in_ready;
  assign w_capture   = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_is_muldiv = (op_sel == 4'b0010) || (op_sel == 4'b0011);

`ifdef ALU_DIVZERO_CHK_EN
  logic r_div_zero;
  assign w_div_zero = (op_sel == 4'b0011) && (op_b == 16'd0);
`else
  assign w_div_zero = 1'b0;
`endif

  // A flagged divide-by-zero skips the multi-cycle window entirely.
  assign w_cnt_load = (w_is_muldiv && !w_div_zero) ? c_muldiv_load : 4'd0;

  always_comb begin
    case (r_sel)
      4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1110, 4'b1111: w_carry_op = 1'b1;
      default:                                              w_carry_op = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  if (r_cnt == 4'd0) w_next_state = S_DONE;
      S_DONE: begin
        if (w_accept)       w_next_state = S_EXEC;
        else if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid = (r_state == S_DONE);
  end

  // Operand registers and execute counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= 16'd0;
      r_b   <= 16'd0;
      r_sel <= 4'd0;
      r_cin <= 1'b0;
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_a   <= op_a;
      r_b   <= op_b;
      r_sel <= op_sel;
      r_cin <= op_cin;
      r_cnt <= w_cnt_load;
    end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sel = r_sel;
  assign alu_cin = r_cin;

`ifdef ALU_DIVZERO_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_zero <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      if (w_accept) r_div_zero <= w_div_zero;
      if (w_capture) res_err <= r_div_zero;
    end
  end

  // Result capture; only updated at the end of execute, so it holds in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= 16'd0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else if (w_capture) begin
      if (r_div_zero) begin
        res       <= 16'hFFFF;
        res_carry <= 1'b0;
        res_zero  <= 1'b0;
      end else begin
        res       <= alu_out;
        res_carry <= w_carry_op & alu_cout;
        res_zero  <= (alu_out == 16'd0);
      end
    end
  end
`else
  assign res_err = 1'b0;

  // Result capture; only updated at the end of execute, so it holds in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= 16'd0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else if (w_capture) begin
      res       <= alu_out;
      res_carry <= w_carry_op & alu_cout;
      res_zero  <= (alu_out == 16'd0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Scoreboard bench for alu_issue_stage with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_sel;
  logic        op_cin;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        res_carry;
  logic        res_zero;
  logic        res_err;

  alu_issue_stage #(.MULDIV_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .op_cin    (op_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  // External ALU stand-in; carry-out is 1 on ops whose carry must be masked.
  always_comb begin
    alu_out  = 16'd0;
    alu_cout = 1'b1;
    case (alu_sel)
      4'b0000: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      4'b0001: {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
      4'b0010: alu_out = alu_a * alu_b;
      4'b0011: alu_out = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
      4'b0110: begin alu_out = {alu_a[14:0], alu_a[15]}; alu_cout = alu_a[15]; end
      4'b1000: alu_out = alu_a & alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    string       nm;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          seen     = 1'b0;
  logic [18:0] snap;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: latency on first presentation, stability while stalled, values on handshake.
  always @(negedge clk) begin
    exp_t cur;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got out_valid=1 res=%0h expected no result", res);
      end else begin
        cur = sb[0];
        if (!seen) begin
          check({cur.nm, "_lat"}, cyc - cur.acc + 1, cur.lat);
          seen = 1'b1;
          snap = {res, res_carry, res_zero, res_err};
        end else begin
          check({cur.nm, "_stable"}, {13'd0, res, res_carry, res_zero, res_err}, {13'd0, snap});
        end
        if (out_ready) begin
          check({cur.nm, "_res"},   res,       cur.res);
          check({cur.nm, "_carry"}, res_carry, cur.c);
          check({cur.nm, "_zero"},  res_zero,  cur.z);
          check({cur.nm, "_err"},   res_err,   cur.e);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                       input logic cin, input logic [15:0] eres, input logic ec,
                       input logic ez, input logic ee, input int elat, input string nm,
                       output int acc);
    exp_t it;
    int   g;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    op_a = a; op_b = b; op_sel = sel; op_cin = cin;
    #1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (!in_ready) check({nm, "_accept_timeout"}, 0, 1);
    acc = cyc + 1;
    it.nm = nm; it.res = eres; it.c = ec; it.z = ez; it.e = ee; it.lat = elat; it.acc = acc;
    sb.push_back(it);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; op_sel = ~sel; op_cin = ~cin;
    check({nm, "_hold_ab"}, {alu_a, alu_b}, {a, b});
    check({nm, "_hold_sel"}, {alu_sel, alu_cin}, {sel, cin});
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acc1;
    int acc2;
    int g;
    rst = 1'b1; in_valid = 1'b0; op_a = 16'h0; op_b = 16'h0; op_sel = 4'h0; op_cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 16'h0000);
    check("rst_flags", {res_carry, res_zero, res_err}, 3'b000);
    check("rst_alu_ops", {alu_a, alu_b, alu_sel, alu_cin}, 37'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    issue(16'hFFFF, 16'h0001, 4'b0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2, "add_wrap", acc1);
    drain();
    issue(16'h1000, 16'h0FFF, 4'b0000, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 2, "add_cin", acc1);
    drain();
    issue(16'h0003, 16'h0005, 4'b0010, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 5, "mul", acc1);
    drain();
    issue(16'h0003, 16'h0005, 4'b0001, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 2, "sub_borrow", acc1);
    drain();
    issue(16'h8001, 16'h0000, 4'b0110, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 2, "rotl", acc1);
    drain();
    issue(16'h0064, 16'h0007, 4'b0011, 1'b0, 16'h000E, 1'b0, 1'b0, 1'b0, 5, "div", acc1);
    drain();
`ifdef ALU_DIVZERO_CHK_EN
    issue(16'h1234, 16'h0000, 4'b0011, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 2, "div_zero", acc1);
`else
    issue(16'h1234, 16'h0000, 4'b0011, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 5, "div_zero", acc1);
`endif
    drain();

    // Stalled result: out_ready low for three cycles of out_valid.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(16'h0005, 16'h0003, 4'b0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 2, "sub_stall", acc1);
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back ANDs: second accepted on the first's DONE edge.
    issue(16'hF0F0, 16'h3C3C, 4'b1000, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 2, "and1", acc1);
    issue(16'h00FF, 16'hFF00, 4'b1000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2, "and2", acc2);
    check("b2b_accept_gap", acc2 - acc1, 2);
    drain();

    // Reset in the middle of a multiply abandons it.
    issue(16'h0007, 16'h0009, 4'b0010, 1'b0, 16'h003F, 1'b0, 1'b0, 1'b0, 5, "mul_abort", acc1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("abort_out_valid", out_valid, 0);
    check("abort_res", res, 16'h0000);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    #1;
    check("abort_no_result", out_valid, 0);
    check("abort_res_after", res, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
